// File: rtl/uart_word_port.sv
// uart_word_port: splits 1/2/4-byte core writes into UART byte pushes and
// gathers UART byte pulls back into zero-extended words; TX and RX run independently.
module uart_word_port #(
  parameter int BIG_ENDIAN = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  input  logic [1:0]  tx_size,
  output logic        tx_ready,
  input  logic        rx_req,
  input  logic [1:0]  rx_size,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic [7:0]  uart_in_data,
  output logic        uart_in_valid,
  input  logic        uart_in_ready,
  output logic        uart_out_valid,
  input  logic [7:0]  uart_out_data,
  input  logic        uart_out_ready
);
  typedef enum logic {TX_IDLE, TX_SEND} tx_st_e;
  typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DONE} rx_st_e;

  function automatic logic [1:0] last_of(input logic [1:0] s);
    return s == 2'b00 ? 2'd0 : s == 2'b01 ? 2'd1 : 2'd3;
  endfunction

  function automatic logic [7:0] pick(input logic [31:0] d, input logic [1:0] last, input logic [1:0] k);
    logic [1:0] i;
    i = (BIG_ENDIAN != 0) ? last - k : k;
    return d[{i, 3'b000} +: 8];
  endfunction

  tx_st_e      tx_st_q, tx_st_d;
  logic [31:0] tx_buf_q, tx_buf_d;
  logic [1:0]  tx_last_q, tx_last_d;
  logic [2:0]  tx_k_q, tx_k_d;
  logic [7:0]  uin_data_q, uin_data_d;
  rx_st_e      rx_st_q, rx_st_d;
  logic [1:0]  rx_last_q, rx_last_d;
  logic [2:0]  rx_k_q, rx_k_d;
  logic [31:0] rx_sh_q, rx_sh_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [1:0]  rx_idx;

  assign rx_idx = (BIG_ENDIAN != 0) ? rx_last_q - rx_k_q[1:0] : rx_k_q[1:0];

  // The outgoing byte is preselected one cycle ahead so uart_in_data comes straight from a flop.
  always_comb begin
    tx_st_d = tx_st_q;
    tx_buf_d = tx_buf_q;
    tx_last_d = tx_last_q;
    tx_k_d = tx_k_q;
    uin_data_d = uin_data_q;
    if (tx_st_q == TX_IDLE && tx_valid) begin
      tx_st_d = TX_SEND;
      tx_buf_d = tx_data;
      tx_last_d = last_of(tx_size);
      tx_k_d = '0;
      uin_data_d = pick(tx_data, last_of(tx_size), 2'd0);
    end else if (tx_st_q == TX_SEND && uart_in_ready) begin
      tx_st_d = tx_k_q == {1'b0, tx_last_q} ? TX_IDLE : TX_SEND;
      tx_k_d = tx_k_q == {1'b0, tx_last_q} ? tx_k_q : tx_k_q + 3'd1;
      uin_data_d = pick(tx_buf_q, tx_last_q, tx_k_q[1:0] + 2'd1);
    end
  end

  always_comb begin
    rx_st_d = rx_st_q;
    rx_last_d = rx_last_q;
    rx_k_d = rx_k_q;
    rx_sh_d = rx_sh_q;
    rx_data_d = rx_data_q;
    if (rx_st_q == RX_IDLE && rx_req) begin
      rx_st_d = RX_RECV;
      rx_last_d = last_of(rx_size);
      rx_k_d = '0;
      rx_sh_d = '0;
    end else if (rx_st_q == RX_RECV && uart_out_ready) begin
      rx_sh_d[{rx_idx, 3'b000} +: 8] = uart_out_data;
      if (rx_k_q == {1'b0, rx_last_q}) begin
        rx_st_d = RX_DONE;
        rx_data_d = rx_sh_d;
      end else begin
        rx_k_d = rx_k_q + 3'd1;
      end
    end else if (rx_st_q == RX_DONE) begin
      rx_st_d = RX_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_st_q <= TX_IDLE;
      tx_buf_q <= '0;
      tx_last_q <= '0;
      tx_k_q <= '0;
      uin_data_q <= '0;
      rx_st_q <= RX_IDLE;
      rx_last_q <= '0;
      rx_k_q <= '0;
      rx_sh_q <= '0;
      rx_data_q <= '0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_buf_q <= tx_buf_d;
      tx_last_q <= tx_last_d;
      tx_k_q <= tx_k_d;
      uin_data_q <= uin_data_d;
      rx_st_q <= rx_st_d;
      rx_last_q <= rx_last_d;
      rx_k_q <= rx_k_d;
      rx_sh_q <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign tx_ready = tx_st_q == TX_IDLE;
  assign uart_in_valid = tx_st_q == TX_SEND;
  assign uart_in_data = uin_data_q;
  assign uart_out_valid = rx_st_q == RX_RECV;
  assign rx_valid = rx_st_q == RX_DONE;
  assign rx_busy = rx_st_q != RX_IDLE;
  assign rx_data = rx_data_q;
endmodule

// File: tb/tb_uart_word_port.sv
// tb_uart_word_port: scoreboard bench driving a little-endian and a big-endian
// instance; expected bytes/words are queued at stimulus time and popped at handshakes.
module tb_uart_word_port;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic        tx_valid_le = 0, tx_valid_be = 0, rx_req_le = 0, rx_req_be = 0;
  logic [31:0] tx_data = 0;
  logic [1:0]  tx_size = 0, rx_size = 0;
  logic        uart_in_ready = 0, uart_out_ready = 0;
  logic [7:0]  uart_out_data = 0;
  logic        tx_ready_le, rx_valid_le, rx_busy_le, uin_v_le, uout_v_le;
  logic        tx_ready_be, rx_valid_be, rx_busy_be, uin_v_be, uout_v_be;
  logic [31:0] rx_data_le, rx_data_be;
  logic [7:0]  uin_d_le, uin_d_be;

  uart_word_port #(.BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_le), .tx_data(tx_data), .tx_size(tx_size),
    .tx_ready(tx_ready_le), .rx_req(rx_req_le), .rx_size(rx_size), .rx_data(rx_data_le),
    .rx_valid(rx_valid_le), .rx_busy(rx_busy_le), .uart_in_data(uin_d_le), .uart_in_valid(uin_v_le),
    .uart_in_ready(uart_in_ready), .uart_out_valid(uout_v_le), .uart_out_data(uart_out_data),
    .uart_out_ready(uart_out_ready));

  uart_word_port #(.BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset(reset), .tx_valid(tx_valid_be), .tx_data(tx_data), .tx_size(tx_size),
    .tx_ready(tx_ready_be), .rx_req(rx_req_be), .rx_size(rx_size), .rx_data(rx_data_be),
    .rx_valid(rx_valid_be), .rx_busy(rx_busy_be), .uart_in_data(uin_d_be), .uart_in_valid(uin_v_be),
    .uart_in_ready(uart_in_ready), .uart_out_valid(uout_v_be), .uart_out_data(uart_out_data),
    .uart_out_ready(uart_out_ready));

  int n_vec = 0, n_bad = 0, tx_stall = 0, rx_gap = 0;
  logic [7:0]  txq_le[$], txq_be[$], src[$];
  logic [31:0] rxq_le[$], rxq_be[$];
  bit taken = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nb(input logic [1:0] s);
    return s == 2'b00 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction

  always @(negedge clk) if (reset) begin
    if (uin_v_le && uart_in_ready) begin
      if (txq_le.size() == 0) chk("tx_le_extra", 32'(txq_le.size()), 1);
      else chk("tx_le_byte", {24'b0, uin_d_le}, {24'b0, txq_le.pop_front()});
    end
    if (uin_v_be && uart_in_ready) begin
      if (txq_be.size() == 0) chk("tx_be_extra", 32'(txq_be.size()), 1);
      else chk("tx_be_byte", {24'b0, uin_d_be}, {24'b0, txq_be.pop_front()});
    end
    if (rx_valid_le) begin
      if (rxq_le.size() == 0) chk("rx_le_extra", 32'(rxq_le.size()), 1);
      else chk("rx_le_word", rx_data_le, rxq_le.pop_front());
    end
    if (rx_valid_be) begin
      if (rxq_be.size() == 0) chk("rx_be_extra", 32'(rxq_be.size()), 1);
      else chk("rx_be_word", rx_data_be, rxq_be.pop_front());
    end
  end

  // Bench-side UART: byte source for RX and randomly stalling sink for TX.
  always @(negedge clk) taken = (uout_v_le || uout_v_be) && uart_out_ready;
  always @(posedge clk) begin
    #1;
    if (taken && src.size() != 0) void'(src.pop_front());
    uart_out_ready = src.size() != 0 && $urandom_range(0, rx_gap) == 0;
    uart_out_data = src.size() != 0 ? src[0] : 8'h00;
    uart_in_ready = tx_stall == 0 || $urandom_range(0, tx_stall) == 0;
  end

  task automatic push_tx(input bit be, input logic [31:0] d, input logic [1:0] s);
    for (int k = 0; k < nb(s); k++) begin
      int i;
      i = be ? nb(s) - 1 - k : k;
      if (be) txq_be.push_back(d[8*i +: 8]);
      else txq_le.push_back(d[8*i +: 8]);
    end
  endtask

  task automatic send(input bit be, input logic [31:0] d, input logic [1:0] s);
    bit ok;
    ok = 0;
    tx_data = d;
    tx_size = s;
    if (be) tx_valid_be = 1;
    else tx_valid_le = 1;
    repeat (200) begin
      @(negedge clk);
      if (be ? tx_ready_be : tx_ready_le) begin
        ok = 1;
        break;
      end
    end
    chk("tx_accept", {31'b0, ok}, 1);
    @(posedge clk);
    #1;
    tx_valid_le = 0;
    tx_valid_be = 0;
  endtask

  task automatic recv(input bit be, input logic [1:0] s, input logic [31:0] b,
                      input logic [31:0] exp, input bit poke);
    bit ok;
    ok = 0;
    for (int k = 0; k < nb(s); k++) src.push_back(b[8*k +: 8]);
    if (be) rxq_be.push_back(exp);
    else rxq_le.push_back(exp);
    rx_size = s;
    if (be) rx_req_be = 1;
    else rx_req_le = 1;
    @(posedge clk);
    #1;
    rx_req_le = 0;
    rx_req_be = 0;
    chk("rx_busy_on", {31'b0, be ? rx_busy_be : rx_busy_le}, 1);
    if (poke) begin
      rx_size = 2'b00;
      rx_req_le = 1;
      @(posedge clk);
      #1;
      rx_req_le = 0;
      rx_size = s;
    end
    repeat (300) begin
      @(posedge clk);
      if ((be ? rxq_be.size() : rxq_le.size()) == 0) begin
        ok = 1;
        break;
      end
    end
    #1;
    chk("rx_done", {31'b0, ok}, 1);
  endtask

  task automatic drain_tx();
    bit ok;
    ok = 0;
    repeat (300) begin
      @(posedge clk);
      if (txq_le.size() == 0 && txq_be.size() == 0) begin
        ok = 1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("tx_drain", {31'b0, ok}, 1);
    chk("tx_idle_le", {31'b0, tx_ready_le}, 1);
    chk("tx_idle_be", {31'b0, tx_ready_be}, 1);
  endtask

  initial begin
    logic [31:0] d, b, exp;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", {31'b0, tx_ready_le}, 1);
    chk("rst_in_valid", {31'b0, uin_v_le}, 0);
    chk("rst_in_data", {24'b0, uin_d_le}, 0);
    chk("rst_out_valid", {31'b0, uout_v_le}, 0);
    chk("rst_rx_valid", {31'b0, rx_valid_le}, 0);
    chk("rst_rx_busy", {31'b0, rx_busy_le}, 0);
    chk("rst_rx_data", rx_data_le, 0);
    chk("rst_be_ready", {31'b0, tx_ready_be}, 1);
    reset = 1;
    @(posedge clk);
    #1;

    push_tx(0, 32'h0, 2'b00);
    void'(txq_le.pop_back());
    txq_le.push_back(8'h44); txq_le.push_back(8'h33); txq_le.push_back(8'h22); txq_le.push_back(8'h11);
    send(0, 32'h11223344, 2'b10);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t2_valid", {31'b0, uin_v_le}, 1);
    end
    @(negedge clk);
    chk("t2_ready_back", {31'b0, tx_ready_le}, 1);
    chk("t2_valid_off", {31'b0, uin_v_le}, 0);
    @(posedge clk);
    #1;

    txq_le.push_back(8'hEF); txq_le.push_back(8'hBE);
    send(0, 32'hDEADBEEF, 2'b10);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 0;
    #1;
    chk("t1_valid_rst", {31'b0, uin_v_le}, 0);
    chk("t1_ready_rst", {31'b0, tx_ready_le}, 1);
    chk("t1_two_sent", 32'(txq_le.size()), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("t1_no_resume", {31'b0, uin_v_le}, 0);
    chk("t1_ready_idle", {31'b0, tx_ready_le}, 1);

    txq_be.push_back(8'hCC); txq_be.push_back(8'hDD);
    send(1, 32'hAABBCCDD, 2'b01);
    txq_be.push_back(8'h5A);
    send(1, 32'h0000005A, 2'b00);
    drain_tx();

    rx_gap = 3;
    recv(0, 2'b10, 32'h12345678, 32'h12345678, 1);
    chk("t4_idle", {31'b0, rx_busy_le}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_hold", rx_data_le, 32'h12345678);
    recv(0, 2'b00, 32'h00000080, 32'h00000080, 0);
    recv(1, 2'b01, 32'h00003412, 32'h00001234, 0);
    recv(1, 2'b10, 32'h44332211, 32'h11223344, 0);

    tx_stall = 2;
    rx_gap = 2;
    repeat (5) begin
      d = $urandom;
      b = $urandom;
      exp = {16'b0, b[15:0]};
      push_tx(0, d, 2'b10);
      fork
        send(0, d, 2'b10);
        recv(0, 2'b01, b, exp, 0);
      join
      drain_tx();
    end
    tx_stall = 0;
    rx_gap = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("txq_left", 32'(txq_le.size() + txq_be.size()), 0);
    chk("rxq_left", 32'(rxq_le.size() + rxq_be.size()), 0);
    chk("src_left", 32'(src.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
